instr_mem_sync: RTL and testbench
=================================

Name: instr_mem_sync

Overview:
Parametrised successor to the combinational instruction ROM. It provides a synchronous, registered-read instruction store with a runtime program-load port, so programs are written through ports rather than from initial blocks. Other additions are a post-reset clear sequencer, pipeline stall hold, optional byte addressing, and out-of-range and misalignment fault flags. It sits between the PC/fetch stage and the IF/ID pipeline register.

Parameters:
WIDTH, 32, instruction word width in bits
DEPTH, 128, number of instruction words (need not be a power of two)
ADDR_W, 32, width of the fetch and load address ports
BYTE_ADDR, 0, 0 = address is a word index; 1 = byte address, index = address>>2
NOP_WORD, 0, word used for clear fill and for fault returns
CLEAR_ON_RESET, 1, 1 = run the clear sequence after reset; 0 = keep contents and go straight to RUN

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
rd_en  input  1  fetch request
address  input  ADDR_W  fetch address
stall  input  1  hold the current fetch output
instruction  output  WIDTH  registered fetched word
instr_valid  output  1  instruction holds a fetched word
fault  output  1  the registered fetch was out of range or misaligned
ld_en  input  1  program-load write request
ld_addr  input  ADDR_W  load address, same addressing mode as address
ld_data  input  WIDTH  load data
ld_ack  output  1  one-cycle pulse: load handled
ld_err  output  1  qualifies ld_ack: load was dropped (out of range or misaligned)
ready  output  1  block is in RUN

Behaviour:
- Reset (asynchronous, while rst=1):
  - instruction=NOP_WORD; instr_valid, fault, ld_ack, ld_err and ready all 0.
  - Clear counter=0.
  - State=CLEAR if CLEAR_ON_RESET=1, else RUN.
- States: CLEAR, RUN.
- CLEAR:
  - Writes NOP_WORD to mem[cnt] each cycle and increments cnt.
  - After cnt=DEPTH-1 is written, moves to RUN. CLEAR lasts exactly DEPTH cycles after reset release.
  - rd_en and ld_en are ignored: no ack, instr_valid stays 0.
  - Reset asserted mid-CLEAR restarts the counter from 0.
- RUN: ready=1, registered in the cycle the state becomes RUN.
- Index decode (applies to both fetch and load):
  - idx = address if BYTE_ADDR=0, else address[ADDR_W-1:2].
  - Bad access when idx >= DEPTH, or when BYTE_ADDR=1 and address[1:0] != 0.
- Fetch (RUN), evaluated at each rising edge:
  - stall=1: instruction, instr_valid and fault all hold, regardless of rd_en.
  - stall=0, rd_en=1, good access: instruction<=mem[idx], instr_valid<=1, fault<=0. Latency is 1 cycle.
  - stall=0, rd_en=1, bad access: instruction<=NOP_WORD, instr_valid<=1, fault<=1.
  - stall=0, rd_en=0: instr_valid<=0, fault<=0, instruction holds its last value.
- Load (RUN):
  - ld_en=1 with good ld_addr writes mem[idx]<=ld_data at that edge; ld_ack=1 and ld_err=0 during the following cycle.
  - Bad ld_addr: no write; ld_ack=1 and ld_err=1 for one cycle.
  - ld_en held high for N cycles produces N writes and N ack pulses, fully pipelined with no backpressure.
  - Loads proceed regardless of stall.
- Simultaneous fetch and load to the same index: the fetch returns the old contents (read-before-write). A fetch in the next cycle returns the new word.
- Reset during RUN:
  - CLEAR_ON_RESET=1: contents are wiped by the clear sequence.
  - CLEAR_ON_RESET=0: contents are retained and the block returns to RUN one cycle after release.
- Width rules:
  - Address bits above those needed to reach DEPTH take part in the range check; they are not truncated.
  - No wrap-around: idx=DEPTH faults, it does not alias to 0.

Test Plan:
- Reset release with DEPTH=128 → ready=0 for 128 cycles, then 1. A fetch of any index < 128 returns 0 with fault=0.
- Load word index 4 = 0x04432800, then fetch rd_en=1, address=4 → next cycle instruction=0x04432800, instr_valid=1. ld_ack pulses one cycle after the write with ld_err=0.
- Fetch idx 5 (loaded 0x11), then stall=1 for 3 cycles with address switched to 6 → instruction stays 0x11 and instr_valid stays 1. After stall drops, instruction = contents of idx 6.
- Fetch address=128 (DEPTH=128) → instruction=NOP_WORD, fault=1, instr_valid=1. Load to 200 → ld_ack=1, ld_err=1, and no entry changes.
- BYTE_ADDR=1: fetch address=0x10 → word 4. Fetch address=0x12 → fault=1. Same-cycle load and fetch of idx 7 (old 0xAA, new 0xBB) → fetch returns 0xAA; the next fetch returns 0xBB.
- Assert rst mid-CLEAR at cnt=50 → clear restarts and ready rises 128 cycles after release. With CLEAR_ON_RESET=0, a loaded word survives reset.

Source files
------------

// File: rtl/instr_mem_sync.sv
// instr_mem_sync: registered-read instruction store with a program-load port and a post-reset clear sequencer
module instr_mem_sync #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 128,
    parameter int ADDR_W = 32,
    parameter int BYTE_ADDR = 0,
    parameter logic [WIDTH-1:0] NOP_WORD = '0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] address,
    input  logic              stall,
    output logic [WIDTH-1:0]  instruction,
    output logic              instr_valid,
    output logic              fault,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [WIDTH-1:0]  ld_data,
    output logic              ld_ack,
    output logic              ld_err,
    output logic              ready
);
    localparam int CW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(DEPTH);
    typedef enum logic {CLEAR, RUN} state_t;
    state_t state, nxt;
    logic [CW-1:0] cnt;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] f_idx, l_idx;
    logic f_bad, l_bad, run, clr;
    // index decode and range/alignment check; full-width compare so high bits cannot alias
    always_comb begin
        f_idx = BYTE_ADDR != 0 ? address >> 2 : address;
        l_idx = BYTE_ADDR != 0 ? ld_addr >> 2 : ld_addr;
        f_bad = {1'b0, f_idx} >= DEPTH_X || (BYTE_ADDR != 0 && address[1:0] != 2'b00);
        l_bad = {1'b0, l_idx} >= DEPTH_X || (BYTE_ADDR != 0 && ld_addr[1:0] != 2'b00);
        run = state == RUN;
        clr = state == CLEAR;
        nxt = clr && cnt == CW'(DEPTH - 1) ? RUN : state;
    end
    // state, clear counter, fetch register and load acknowledge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= CLEAR_ON_RESET != 0 ? CLEAR : RUN;
            cnt <= '0;
            ready <= 1'b0;
            instruction <= NOP_WORD;
            instr_valid <= 1'b0;
            fault <= 1'b0;
            ld_ack <= 1'b0;
            ld_err <= 1'b0;
        end else begin
            state <= nxt;
            cnt <= clr ? cnt + 1'b1 : '0;
            ready <= nxt == RUN;
            ld_ack <= run && ld_en;
            ld_err <= run && ld_en && l_bad;
            if (run && !stall) begin
                instr_valid <= rd_en;
                fault <= rd_en && f_bad;
                if (rd_en) instruction <= f_bad ? NOP_WORD : mem[f_idx[CW-1:0]];
            end
        end
    end
    // single write port shared by the clear sequencer and the load port; old data is read on a same-edge fetch
    always_ff @(posedge clk) begin
        if (!rst && (clr || (run && ld_en && !l_bad)))
            mem[clr ? cnt : l_idx[CW-1:0]] <= clr ? NOP_WORD : ld_data;
    end
endmodule

// File: tb/tb_instr_mem_sync.sv
// tb_instr_mem_sync: directed checks of clear sequencing, fetch, stall, load, faults and reset behaviour
module tb_instr_mem_sync;
    logic clk = 0, rst = 1, rd_en = 0, stall = 0, ld_en = 0;
    logic [31:0] address = 0, ld_addr = 0, ld_data = 0;
    logic [31:0] a_ins, b_ins, c_ins;
    logic a_v, a_f, a_ack, a_err, a_rdy;
    logic b_v, b_f, b_ack, b_err, b_rdy;
    logic c_v, c_f, c_ack, c_err, c_rdy;
    int tests = 0, failed = 0;

    always #5 clk = ~clk;

    instr_mem_sync u_a (.clk(clk), .rst(rst), .rd_en(rd_en), .address(address), .stall(stall),
        .instruction(a_ins), .instr_valid(a_v), .fault(a_f), .ld_en(ld_en), .ld_addr(ld_addr),
        .ld_data(ld_data), .ld_ack(a_ack), .ld_err(a_err), .ready(a_rdy));
    instr_mem_sync #(.DEPTH(16), .BYTE_ADDR(1)) u_b (.clk(clk), .rst(rst), .rd_en(rd_en),
        .address(address), .stall(stall), .instruction(b_ins), .instr_valid(b_v), .fault(b_f),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data), .ld_ack(b_ack), .ld_err(b_err), .ready(b_rdy));
    instr_mem_sync #(.DEPTH(16), .CLEAR_ON_RESET(0)) u_c (.clk(clk), .rst(rst), .rd_en(rd_en),
        .address(address), .stall(stall), .instruction(c_ins), .instr_valid(c_v), .fault(c_f),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data), .ld_ack(c_ack), .ld_err(c_err), .ready(c_rdy));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #12;
        chk("rst_ins", a_ins, 0);
        chk("rst_valid", {31'b0, a_v}, 0);
        chk("rst_fault", {31'b0, a_f}, 0);
        chk("rst_ack", {31'b0, a_ack}, 0);
        chk("rst_ready_a", {31'b0, a_rdy}, 0);
        chk("rst_ready_c", {31'b0, c_rdy}, 0);
        rd_en = 1; address = 100; ld_en = 1; ld_addr = 100; ld_data = 32'hDEAD;
        @(negedge clk) rst = 0;
        for (int i = 1; i <= 128; i++) begin
            if (i == 10) begin rd_en = 0; ld_en = 0; end
            tick();
            if (i == 1) chk("c_ready_1cyc", {31'b0, c_rdy}, 1);
            if (i == 5) begin
                chk("clear_no_valid", {31'b0, a_v}, 0);
                chk("clear_no_ack", {31'b0, a_ack}, 0);
                chk("c_bad_ld_err", {30'b0, c_ack, c_err}, 3);
            end
            if (i == 15) chk("b_ready_15", {31'b0, b_rdy}, 0);
            if (i == 16) chk("b_ready_16", {31'b0, b_rdy}, 1);
            if (i == 127) chk("a_ready_127", {31'b0, a_rdy}, 0);
            if (i == 128) chk("a_ready_128", {31'b0, a_rdy}, 1);
        end
        rd_en = 1; address = 3; tick();
        chk("clr_fetch_ins", a_ins, 0);
        chk("clr_fetch_vf", {30'b0, a_v, a_f}, 2);
        rd_en = 0; ld_en = 1; ld_addr = 4; ld_data = 32'h04432800; tick();
        chk("ld4_ack", {30'b0, a_ack, a_err}, 2);
        chk("rd0_valid", {31'b0, a_v}, 0);
        ld_en = 0; rd_en = 1; address = 4; tick();
        chk("fetch4", a_ins, 32'h04432800);
        chk("fetch4_v", {31'b0, a_v}, 1);
        chk("ack_one_cycle", {31'b0, a_ack}, 0);
        chk("b_fetch_byte4", b_ins, 32'h04432800);
        chk("c_fetch4", c_ins, 32'h04432800);
        rd_en = 0; ld_en = 1; ld_addr = 5; ld_data = 32'h11; tick();
        chk("ld5_ack", {30'b0, a_ack, a_err}, 2);
        chk("b_misalign_ld", {30'b0, b_ack, b_err}, 3);
        ld_addr = 6; ld_data = 32'h22; tick();
        chk("ld6_ack", {30'b0, a_ack, a_err}, 2);
        ld_en = 0; rd_en = 1; address = 5; tick();
        chk("fetch5", a_ins, 32'h11);
        stall = 1; address = 6;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_ins", a_ins, 32'h11);
            chk("stall_v", {31'b0, a_v}, 1);
        end
        stall = 0; tick();
        chk("after_stall", a_ins, 32'h22);
        rd_en = 0; tick();
        chk("idle_valid", {31'b0, a_v}, 0);
        chk("idle_hold", a_ins, 32'h22);
        rd_en = 1; address = 128; tick();
        chk("oor_ins", a_ins, 0);
        chk("oor_vf", {30'b0, a_v, a_f}, 3);
        address = 32'h8000_0004; tick();
        chk("high_bits_fault", {31'b0, a_f}, 1);
        rd_en = 0; ld_en = 1; ld_addr = 200; ld_data = 32'hBAD; tick();
        chk("ld200_err", {30'b0, a_ack, a_err}, 3);
        ld_en = 0; rd_en = 1; address = 72; tick();
        chk("no_alias72", a_ins, 0);
        chk("no_alias72_f", {31'b0, a_f}, 0);
        address = 4; tick();
        chk("idx4_intact", a_ins, 32'h04432800);
        rd_en = 0; ld_en = 1; ld_addr = 32'h10; ld_data = 32'h55; tick();
        chk("b_ld10_ack", {30'b0, b_ack, b_err}, 2);
        ld_en = 0; rd_en = 1; address = 32'h10; tick();
        chk("b_fetch10", b_ins, 32'h55);
        address = 32'h12; tick();
        chk("b_misalign_f", {31'b0, b_f}, 1);
        chk("b_misalign_ins", b_ins, 0);
        address = 64; tick();
        chk("b_depth_f", {31'b0, b_f}, 1);
        rd_en = 0; ld_en = 1; ld_addr = 32'h1C; ld_data = 32'hAA; tick();
        ld_data = 32'hBB; rd_en = 1; address = 32'h1C; tick();
        chk("b_rbw_old", b_ins, 32'hAA);
        ld_en = 0; tick();
        chk("b_rbw_new", b_ins, 32'hBB);
        rd_en = 0; rst = 1; #1;
        chk("rst_async_ready", {31'b0, a_rdy}, 0);
        chk("rst_async_ins", b_ins, 0);
        @(negedge clk) rst = 0;
        repeat (50) tick();
        chk("mid_clear_ready", {31'b0, a_rdy}, 0);
        rst = 1; tick();
        @(negedge clk) rst = 0;
        for (int i = 1; i <= 128; i++) begin
            tick();
            if (i == 1) begin
                chk("c_ready_again", {31'b0, c_rdy}, 1);
                rd_en = 1; address = 4;
            end
            if (i == 2) begin
                chk("c_retained", c_ins, 32'h04432800);
                rd_en = 0;
            end
            if (i == 127) chk("restart_127", {31'b0, a_rdy}, 0);
            if (i == 128) chk("restart_128", {31'b0, a_rdy}, 1);
        end
        rd_en = 1; address = 4; tick();
        chk("a_wiped", a_ins, 0);
        chk("a_wiped_f", {31'b0, a_f}, 0);
        chk("b_wiped", b_ins, 0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
